// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, jump flushes, data-memory wait
// freezing with timeout detection, and stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_mem_read,
  input  logic                      ex_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wreg_addr,
  input  logic                      jump_flag,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_bubble,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1'b1);
  localparam logic [WAIT_W-1:0]    WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_SAT   = {CNT_WIDTH{1'b1}};

  // CPU_WIDTH carries no datapath here; this empty guard only documents a sane range.
  if (CPU_WIDTH < 1) begin : g_cpu_width_invalid
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t                state_r, state_n;
  logic [WAIT_W-1:0]     wait_r, wait_n;
  logic                  mem_err_r, err_set_s;
  logic [CNT_WIDTH-1:0]  stall_cnt_r, flush_cnt_r;
  logic                  freeze_s, jump_s, lu_hazard_s;

  assign freeze_s    = dmem_req & ~dmem_ready;
  assign jump_s      = jump_flag & ~freeze_s;
  assign lu_hazard_s = ex_mem_read & ex_reg_write & (ex_wreg_addr != {REG_ADDR_WIDTH{1'b0}}) &
                       ((id_rs1_used & (id_rs1_addr == ex_wreg_addr)) |
                        (id_rs2_used & (id_rs2_addr == ex_wreg_addr)));

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Next-state and pipeline control; priority is freeze > jump > load-use.
  always_comb begin
    state_n       = state_r;
    wait_n        = wait_r;
    err_set_s     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      state_n = RUN;
      wait_n  = WAIT_ZERO;
    end else if (state_r == ERROR) begin
      {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} = 5'b11111;
    end else if (freeze_s) begin
      {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} = 5'b11111;
      if (state_r != MEM_WAIT) begin
        state_n = MEM_WAIT;
        wait_n  = WAIT_ONE;
      end else if (wait_r == WAIT_MAX) begin
        state_n   = ERROR;
        err_set_s = 1'b1;
      end else begin
        wait_n = wait_r + WAIT_ONE;
      end
    end else begin
      wait_n = WAIT_ZERO;
      if (jump_s) begin
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
        state_n = RUN;
      end else if (lu_hazard_s && (state_r != LU_STALL)) begin
        // The one-cycle interlock bubble is never re-armed from LU_STALL itself.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        state_n     = LU_STALL;
      end else begin
        state_n = RUN;
      end
    end
  end

  // State, wait counter, sticky error and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      wait_r      <= WAIT_ZERO;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_n;
      wait_r    <= wait_n;
      mem_err_r <= mem_err_r | err_set_s;
      if (pc_stall && (stall_cnt_r != CNT_SAT)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (if_id_flush && (flush_cnt_r != CNT_SAT)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: one task per scenario, expected
// control vectors and counter values computed by hand.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_wreg_addr;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_reg_write;
  logic       jump_flag, dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [7:0]  outs;

  int checks = 0;
  int passed = 0;

  // Output vector: {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, ex_mem flushes, bubble}
  localparam logic [7:0] NONE      = 8'b0000_0000;
  localparam logic [7:0] STALL_ALL = 8'b1111_0001;
  localparam logic [7:0] FLUSH_ALL = 8'b0000_1110;
  localparam logic [7:0] LU_OUT    = 8'b1100_0100;
  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_WAIT = 2'd2, S_ERR = 2'd3;

  assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble};

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CPU_WIDTH(32), .MEM_TIMEOUT(15), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_wreg_addr(ex_wreg_addr),
    .jump_flag(jump_flag), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_wreg_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    jump_flag = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wreg_addr = 5'd5;
    id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_load_use();
    jump_flag = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL reset_outs: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    checks++; if (flush_cnt !== 16'd0) $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b want 0", mem_err); else passed++;
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL reset_idle_outs: got %b want %b", outs, NONE); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    @(negedge clk);
    checks++; if (outs !== LU_OUT) $display("FAIL lu_outs: got %b want %b", outs, LU_OUT); else passed++;
    next_cycle();
    checks++; if (dut.state_r !== S_LU) $display("FAIL lu_state: got %0d want %0d", dut.state_r, S_LU); else passed++;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL lu_second_cycle: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    set_idle();
    checks++; if (dut.state_r !== S_RUN) $display("FAIL lu_back_run: got %0d want %0d", dut.state_r, S_RUN); else passed++;
    checks++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else passed++;
    checks++; if (flush_cnt !== 16'd0) $display("FAIL lu_flush_cnt: got %0d want 0", flush_cnt); else passed++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_load_use();
    ex_wreg_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_addr = 5'd0;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL nohaz_x0: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    set_load_use();
    id_rs2_used = 1'b0;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL nohaz_unused: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    set_load_use();
    ex_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL nohaz_not_load: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    set_idle();
    checks++; if (stall_cnt !== 16'd0) $display("FAIL nohaz_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    set_load_use();
    id_rs2_used = 1'b0; id_rs1_addr = 5'd5;
    @(negedge clk);
    checks++; if (outs !== LU_OUT) $display("FAIL rs1_hazard: got %b want %b", outs, LU_OUT); else passed++;
    next_cycle();
    set_idle();
  endtask

  task automatic test_jump_hazard();
    do_reset();
    set_load_use();
    jump_flag = 1'b1;
    @(negedge clk);
    checks++; if (outs !== FLUSH_ALL) $display("FAIL jump_lu_outs: got %b want %b", outs, FLUSH_ALL); else passed++;
    next_cycle();
    set_idle();
    checks++; if (dut.state_r !== S_RUN) $display("FAIL jump_lu_state: got %0d want %0d", dut.state_r, S_RUN); else passed++;
    checks++; if (flush_cnt !== 16'd1) $display("FAIL jump_flush_cnt: got %0d want 1", flush_cnt); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL jump_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL jump_one_cycle: got %b want %b", outs, NONE); else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (outs !== STALL_ALL) $display("FAIL wait_outs[%0d]: got %b want %b", i, outs, STALL_ALL); else passed++;
      next_cycle();
    end
    checks++; if (dut.state_r !== S_WAIT) $display("FAIL wait_state: got %0d want %0d", dut.state_r, S_WAIT); else passed++;
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL wait_release: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    set_idle();
    checks++; if (dut.state_r !== S_RUN) $display("FAIL wait_back_run: got %0d want %0d", dut.state_r, S_RUN); else passed++;
    checks++; if (stall_cnt !== 16'd3) $display("FAIL wait_stall_cnt: got %0d want 3", stall_cnt); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL wait_mem_err: got %b want 0", mem_err); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (outs !== STALL_ALL) $display("FAIL tmo_outs[%0d]: got %b want %b", i, outs, STALL_ALL); else passed++;
      next_cycle();
      if (i == 14) begin
        checks++; if (mem_err !== 1'b0) $display("FAIL tmo_early_err: got %b want 0", mem_err); else passed++;
      end
    end
    checks++; if (dut.state_r !== S_ERR) $display("FAIL tmo_state: got %0d want %0d", dut.state_r, S_ERR); else passed++;
    checks++; if (mem_err !== 1'b1) $display("FAIL tmo_mem_err: got %b want 1", mem_err); else passed++;
    dmem_req = 1'b0; dmem_ready = 1'b1; jump_flag = 1'b1;
    @(negedge clk);
    checks++; if (outs !== STALL_ALL) $display("FAIL err_ignores_inputs: got %b want %b", outs, STALL_ALL); else passed++;
    next_cycle();
    checks++; if (mem_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", mem_err); else passed++;
    checks++; if (stall_cnt !== 16'd17) $display("FAIL err_stall_cnt: got %0d want 17", stall_cnt); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL err_rst_outs: got %b want %b", outs, NONE); else passed++;
    next_cycle();
    rst = 1'b0;
    set_idle();
    checks++; if (dut.state_r !== S_RUN) $display("FAIL err_rst_state: got %0d want %0d", dut.state_r, S_RUN); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL err_rst_mem_err: got %b want 0", mem_err); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL err_rst_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    @(negedge clk);
    checks++; if (outs !== NONE) $display("FAIL err_rst_idle: got %b want %b", outs, NONE); else passed++;
  endtask

  task automatic test_jump_during_freeze();
    do_reset();
    jump_flag = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (outs !== STALL_ALL) $display("FAIL jf_freeze[%0d]: got %b want %b", i, outs, STALL_ALL); else passed++;
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (outs !== FLUSH_ALL) $display("FAIL jf_release: got %b want %b", outs, FLUSH_ALL); else passed++;
    next_cycle();
    set_idle();
    checks++; if (flush_cnt !== 16'd1) $display("FAIL jf_flush_cnt: got %0d want 1", flush_cnt); else passed++;
    checks++; if (stall_cnt !== 16'd2) $display("FAIL jf_stall_cnt: got %0d want 2", stall_cnt); else passed++;
    checks++; if (dut.state_r !== S_RUN) $display("FAIL jf_state: got %0d want %0d", dut.state_r, S_RUN); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_load_use();
    @(negedge clk);
    checks++; if (outs !== LU_OUT) $display("FAIL b2b_lu: got %b want %b", outs, LU_OUT); else passed++;
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (outs !== STALL_ALL) $display("FAIL b2b_freeze_in_lu: got %b want %b", outs, STALL_ALL); else passed++;
    next_cycle();
    checks++; if (dut.state_r !== S_WAIT) $display("FAIL b2b_state: got %0d want %0d", dut.state_r, S_WAIT); else passed++;
    set_idle();
    next_cycle();
    checks++; if (stall_cnt !== 16'd2) $display("FAIL b2b_stall_cnt: got %0d want 2", stall_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_jump_hazard();
    test_mem_wait();
    test_timeout();
    test_jump_during_freeze();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter CPU_WIDTH, default 32, datapath width (informational; no data ports use it).
REQ-003 Parameter MEM_TIMEOUT, default 15, max consecutive data-memory wait cycles before error.
REQ-004 Parameter CNT_WIDTH, default 16, width of performance counters.
REQ-005 clk  in  1  single system clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 id_rs1_addr, id_rs2_addr  in  REG_ADDR_WIDTH each  source registers of instruction in ID.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
REQ-009 ex_mem_read  in  1  instruction in EX is a load.
REQ-010 ex_reg_write  in  1  instruction in EX writes the register file.
REQ-011 ex_wreg_addr  in  REG_ADDR_WIDTH  destination register of EX instruction.
REQ-012 jump_flag  in  1  taken branch/jump resolved in MEM stage.
REQ-013 dmem_req  in  1  MEM-stage instruction is accessing data memory (read or write).
REQ-014 dmem_ready  in  1  data memory completes access this cycle.
REQ-015 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the respective register.
REQ-016 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  zero control fields of the respective register on next edge.
REQ-017 mem_wb_bubble  out  1  insert zero-control bubble into MEM/WB.
REQ-018 mem_err  out  1  sticky data-memory timeout error.
REQ-019 stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters.

Function
REQ-020 Control outputs SHALL be combinational from registered state and current inputs; state, wait counter, mem_err and counters SHALL be registered.
REQ-021 FSM states SHALL be RUN, LU_STALL, MEM_WAIT, ERROR.
REQ-022 freeze := dmem_req & ~dmem_ready; in RUN, LU_STALL or MEM_WAIT with freeze=1, all four *_stall and mem_wb_bubble SHALL be 1 and all flushes 0.
REQ-023 jump := jump_flag & ~freeze; jump=1 SHALL assert if_id_flush, id_ex_flush, ex_mem_flush for exactly that cycle, stalls 0.
REQ-024 lu_hazard := ex_mem_read & ex_reg_write & (ex_wreg_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_wreg_addr) | (id_rs2_used & id_rs2_addr==ex_wreg_addr)).
REQ-025 In RUN with lu_hazard=1, ~freeze, ~jump: pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0; next state LU_STALL.
REQ-026 Priority SHALL be freeze > jump > lu_hazard; jump coincident with lu_hazard SHALL produce flush only, next state RUN.
REQ-027 LU_STALL SHALL last exactly one cycle; lu_hazard SHALL be ignored in it; freeze and jump still apply; next state MEM_WAIT if freeze else RUN.
REQ-028 RUN with freeze=1 SHALL go to MEM_WAIT with wait counter loaded to 1.
REQ-029 MEM_WAIT: dmem_ready=1 SHALL return to RUN, clear wait counter, outputs per REQ-023..025 that cycle; else counter increments.
REQ-030 MEM_WAIT with freeze=1 and counter==MEM_TIMEOUT SHALL go to ERROR and set mem_err.
REQ-031 ERROR SHALL assert all stalls and mem_wb_bubble, ignore all inputs, exit only on rst.
REQ-032 stall_cnt SHALL increment each cycle pc_stall=1; flush_cnt each cycle if_id_flush=1; both saturate at all-ones.
REQ-033 jump_flag held during freeze SHALL be honored on the first non-freeze cycle (EX/MEM is held so jump_flag persists).

Reset
REQ-034 rst=1 at a clock edge SHALL force state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0, regardless of current state (including ERROR or mid-MEM_WAIT).
REQ-035 While rst=1 all stall, flush and bubble outputs SHALL be 0.

Verification
REQ-036 Load x5 in EX, ID reads rs2=x5 (used) -> one cycle pc_stall=if_id_stall=id_ex_flush=1, state LU_STALL, next cycle all 0, stall_cnt=1.
REQ-037 Same as REQ-036 but ex_wreg_addr=0 or id_rs2_used=0 -> no stall, stall_cnt=0.
REQ-038 jump_flag=1 with lu_hazard=1 -> three flushes only, no stall, flush_cnt=1, state RUN.
REQ-039 dmem_req=1, dmem_ready low 3 cycles then high -> all stalls+bubble 3 cycles, released 4th cycle, stall_cnt=3.
REQ-040 dmem_ready held low 16 cycles with MEM_TIMEOUT=15 -> ERROR, mem_err=1 sticky; rst pulse -> RUN, mem_err=0, counters 0.
REQ-041 jump_flag=1 during 2-cycle freeze -> no flush during freeze, flushes asserted on release cycle, flush_cnt=1.
